// File: rtl/subtr_divider_if.sv
// Handshake and operand/result bundle for the restoring divider.
// master drives requests, slave (the divider) returns results.
interface subtr_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );
endinterface

// File: rtl/subtr_divider.sv
// Unsigned restoring divider: one quotient bit per cycle through a
// shared full subtractor; divide-by-zero completes in a single cycle.
module full_subtr #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   s
);
  assign s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
endmodule

module subtr_divider #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  subtr_divider_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] r, q, dvs;
  logic [WIDTH-1:0] t, r_n, q_n;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH:0]   s;
  logic [3:0]       cnt;
  logic             m, take, accept, last, dbz, zero;

  // m is the bit shifted out of R; when set, T+256 always covers divisor
  assign m    = r[WIDTH-1];
  assign t    = {r[WIDTH-2:0], q[WIDTH-1]};
  assign take = m | ~s[WIDTH];
  assign r_n  = take ? s[WIDTH-1:0] : t;
  assign q_n  = {q[WIDTH-2:0], take};

  full_subtr #(.WIDTH(WIDTH)) u_sub (
    .a   (t),
    .b   (dvs),
    .cin (1'b0),
    .s   (s)
  );

  assign accept = bus.start & (state != BUSY);
  assign zero   = bus.divisor == '0;
  assign last   = cnt == 4'd1;

  assign bus.busy        = state == BUSY;
  assign bus.done        = state == DONE;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) state_n = zero ? DONE : BUSY;
        else           state_n = IDLE;
      end
      BUSY:    if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      q   <= '0;
      dvs <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      dvs <= bus.divisor;
      dbz <= zero;
      r   <= '0;
      q   <= bus.dividend;
      if (zero) begin
        cnt <= '0;
        quo <= '1;
        rem <= bus.dividend;
      end else begin
        cnt <= 4'd8;
      end
    end else if (state == BUSY) begin
      r   <= r_n;
      q   <= q_n;
      cnt <= cnt - 4'd1;
      if (last) begin
        quo <= q_n;
        rem <= r_n;
      end
    end
  end
endmodule

// File: tb/tb_subtr_divider.sv
// Directed-vector and corner-sequence bench for subtr_divider.
// Timing is sampled on the falling edge; lat counts edges after start.
module tb_subtr_divider;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  subtr_divider_if #(.WIDTH(8)) bus ();

  subtr_divider #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int nb;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // wait for done; lat = edges after the start edge, nb = busy samples
  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL timeout: done not seen within %0d cycles", lat);
    end
  endtask

  task automatic run_op(input int a, input int b,
                        output int lat, output int nb);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, nb);
  endtask

  initial begin
    int lat, nb, a, b, n, seen;
    errors = 0;
    checks = 0;
    vecs[0]  = '{100,   7,  14,   2, 0, 8};
    vecs[1]  = '{255,   1, 255,   0, 0, 8};
    vecs[2]  = '{  5,   9,   0,   5, 0, 8};
    vecs[3]  = '{255, 255,   1,   0, 0, 8};
    vecs[4]  = '{ 42,   0, 255,  42, 1, 0};
    vecs[5]  = '{  0,   5,   0,   0, 0, 8};
    vecs[6]  = '{200,   3,  66,   2, 0, 8};
    vecs[7]  = '{  9,   2,   4,   1, 0, 8};
    vecs[8]  = '{128,  16,   8,   0, 0, 8};
    vecs[9]  = '{  7,   0, 255,   7, 1, 0};
    vecs[10] = '{  1, 255,   0,   1, 0, 8};
    vecs[11] = '{254, 127,   2,   0, 0, 8};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset quotient", int'(bus.quotient), 0);
    chk("reset remainder", int'(bus.remainder), 0);
    chk("reset dbz", int'(bus.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, nb);
      chk($sformatf("v%0d quotient", i), int'(bus.quotient), vecs[i].q);
      chk($sformatf("v%0d remainder", i), int'(bus.remainder), vecs[i].r);
      chk($sformatf("v%0d dbz", i), int'(bus.div_by_zero), vecs[i].z);
      chk($sformatf("v%0d latency", i), lat, vecs[i].nb);
      chk($sformatf("v%0d busy cycles", i), nb, vecs[i].nb);
    end

    // div_by_zero holds past DONE, then clears on the next start
    run_op(42, 0, lat, nb);
    @(negedge clk);
    chk("dbz hold done", int'(bus.done), 0);
    chk("dbz hold flag", int'(bus.div_by_zero), 1);
    chk("dbz hold quotient", int'(bus.quotient), 255);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd10;
    bus.divisor  = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("dbz cleared", int'(bus.div_by_zero), 0);
    wait_done(lat, nb);
    chk("10/5 quotient", int'(bus.quotient), 2);

    // start and operand changes while busy must be ignored
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ignore busy", int'(bus.busy), 1);
    lat = 4;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore latency", lat, 8);
    chk("ignore quotient", int'(bus.quotient), 66);
    chk("ignore remainder", int'(bus.remainder), 2);

    // reset mid-operation aborts with no done pulse
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    chk("abort quotient", int'(bus.quotient), 0);
    chk("abort remainder", int'(bus.remainder), 0);
    chk("abort dbz", int'(bus.div_by_zero), 0);
    seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("abort no done", seen, 0);
    run_op(9, 2, lat, nb);
    chk("post-reset latency", lat, 8);
    chk("post-reset quotient", int'(bus.quotient), 4);
    chk("post-reset remainder", int'(bus.remainder), 1);

    // start held through DONE: next op accepted in the DONE cycle
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(negedge clk);
    wait_done(lat, nb);
    chk("b2b first quotient", int'(bus.quotient), 14);
    bus.dividend = 8'd9;
    bus.divisor  = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b accepted", int'(bus.busy), 1);
    wait_done(lat, nb);
    chk("b2b latency", lat, 8);
    chk("b2b quotient", int'(bus.quotient), 4);
    chk("b2b remainder", int'(bus.remainder), 1);

    // sweep: q*b + r == a with r < b
    n = 0;
    repeat (1000) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 1));
      run_op(a, b, lat, nb);
      checks++;
      if (int'(bus.quotient) * b + int'(bus.remainder) != a ||
          int'(bus.remainder) >= b) begin
        errors++;
        n++;
        if (n < 10)
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                   a, b, bus.quotient, bus.remainder, a / b, a % b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
